// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection,
// flush/hold control and a saturating bubble counter.
package id_ex_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic        alusrc;
    logic        branch;
    logic [1:0]  aluop;
  } id_ex_t;
endpackage

module id_ex_stage
  import id_ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ID_PC,
  input  logic [31:0] ID_ReadData1,
  input  logic [31:0] ID_ReadData2,
  input  logic [31:0] ID_Imm,
  input  logic [4:0]  ID_Rs1,
  input  logic [4:0]  ID_Rs2,
  input  logic [4:0]  ID_Rd,
  input  logic [2:0]  ID_Funct3,
  input  logic        ID_Funct7b5,
  input  logic        ID_RegWrite,
  input  logic        ID_MemRead,
  input  logic        ID_MemWrite,
  input  logic        ID_MemtoReg,
  input  logic        ID_ALUSrc,
  input  logic        ID_Branch,
  input  logic [1:0]  ID_ALUOp,
  input  logic        Flush,
  input  logic        Hold,
  output logic [31:0] EX_PC,
  output logic [31:0] EX_ReadData1,
  output logic [31:0] EX_ReadData2,
  output logic [31:0] EX_Imm,
  output logic [4:0]  EX_Rs1,
  output logic [4:0]  EX_Rs2,
  output logic [4:0]  EX_Rd,
  output logic [2:0]  EX_Funct3,
  output logic        EX_Funct7b5,
  output logic        EX_RegWrite,
  output logic        EX_MemRead,
  output logic        EX_MemWrite,
  output logic        EX_MemtoReg,
  output logic        EX_ALUSrc,
  output logic        EX_Branch,
  output logic [1:0]  EX_ALUOp,
  output logic        EX_Valid,
  output logic        Stall,
  output logic [15:0] BubbleCount
);

  id_ex_t      id_d;
  id_ex_t      ex_q;
  logic        valid_q;
  logic [15:0] cnt_q;
  logic        lu;
  logic        bubble;

  assign id_d = '{
    pc:       ID_PC,
    rd1:      ID_ReadData1,
    rd2:      ID_ReadData2,
    imm:      ID_Imm,
    rs1:      ID_Rs1,
    rs2:      ID_Rs2,
    rd:       ID_Rd,
    funct3:   ID_Funct3,
    funct7b5: ID_Funct7b5,
    regwrite: ID_RegWrite,
    memread:  ID_MemRead,
    memwrite: ID_MemWrite,
    memtoreg: ID_MemtoReg,
    alusrc:   ID_ALUSrc,
    branch:   ID_Branch,
    aluop:    ID_ALUOp
  };

  // rd != 0 also keeps x0 sources from ever matching
  assign lu = valid_q && ex_q.memread
           && (ex_q.rd != 5'd0)
           && ((ex_q.rd == ID_Rs1)
            || (ex_q.rd == ID_Rs2));

  assign Stall  = (lu || Hold) && !Flush;
  assign bubble = Flush || (!Hold && lu);

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q    <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else if (bubble) begin
      ex_q    <= '0;
      valid_q <= 1'b0;
      if (cnt_q != 16'hFFFF)
        cnt_q <= cnt_q + 16'd1;
    end else if (!Hold) begin
      ex_q    <= id_d;
      valid_q <= 1'b1;
    end
  end

  assign EX_PC        = ex_q.pc;
  assign EX_ReadData1 = ex_q.rd1;
  assign EX_ReadData2 = ex_q.rd2;
  assign EX_Imm       = ex_q.imm;
  assign EX_Rs1       = ex_q.rs1;
  assign EX_Rs2       = ex_q.rs2;
  assign EX_Rd        = ex_q.rd;
  assign EX_Funct3    = ex_q.funct3;
  assign EX_Funct7b5  = ex_q.funct7b5;
  assign EX_RegWrite  = ex_q.regwrite;
  assign EX_MemRead   = ex_q.memread;
  assign EX_MemWrite  = ex_q.memwrite;
  assign EX_MemtoReg  = ex_q.memtoreg;
  assign EX_ALUSrc    = ex_q.alusrc;
  assign EX_Branch    = ex_q.branch;
  assign EX_ALUOp     = ex_q.aluop;
  assign EX_Valid     = valid_q;
  assign BubbleCount  = cnt_q;

endmodule
